// File: rtl/flag_branch_if.sv
// Bundle between the ALU/decode side and flag_branch_unit: ALU flag inputs,
// branch request fields and the registered branch resolution returned to fetch.
interface flag_branch_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 9
);
    // Valid-only handshake, no ready: alu_valid and br_valid take effect on a
    // rising edge where stall=0; resolve_valid is a one-cycle pulse that the
    // PC logic must consume in the cycle it is high (it cannot back-pressure).
    logic             alu_valid;
    logic [3:0]       alu_opcode;
    logic             z_in;
    logic             n_in;
    logic             v_in;
    logic             stall;
    logic             br_valid;
    logic             br_reg;
    logic [2:0]       cond;
    logic [WIDTH-1:0] pc_plus2;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] rs_val;
    logic [2:0]       flags_q;
    logic             resolve_valid;
    logic             taken;
    logic [WIDTH-1:0] target;
    logic             flush;

    modport master (
        output alu_valid, alu_opcode, z_in, n_in, v_in, stall,
               br_valid, br_reg, cond, pc_plus2, imm, rs_val,
        input  flags_q, resolve_valid, taken, target, flush
    );

    modport slave (
        input  alu_valid, alu_opcode, z_in, n_in, v_in, stall,
               br_valid, br_reg, cond, pc_plus2, imm, rs_val,
        output flags_q, resolve_valid, taken, target, flush
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Z/N/V flag register plus B/BR condition evaluation with a registered resolution.
// Optional macro FLAG_BYPASS_EN forwards same-cycle ALU flags into branch evaluation.
module flag_branch_unit #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 9
) (
    input  logic         clk,
    input  logic         rst,
    flag_branch_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic [2:0]       flags_q, flags_d;
    logic             resolve_valid_q, resolve_valid_d;
    logic             taken_q, taken_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             flush_q, flush_d;

    logic [2:0]       eval_flags;
    logic             cond_true;
    logic             br_accept;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] b_target;

    // Arithmetic ops write all three flags; logic/shift ops only Z.
    always_comb begin
        flags_d = flags_q;
        if (bus.alu_valid && !bus.stall) begin
            case (bus.alu_opcode)
                OP_ADD, OP_SUB:                 flags_d = {bus.z_in, bus.n_in, bus.v_in};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[2] = bus.z_in;
                default:                        flags_d = flags_q;
            endcase
        end
    end

`ifdef FLAG_BYPASS_EN
    assign eval_flags = flags_d;
`else
    assign eval_flags = flags_q;
`endif

    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            3'b000:  cond_true = !eval_flags[2];
            3'b001:  cond_true = eval_flags[2];
            3'b010:  cond_true = !eval_flags[2] && !eval_flags[1];
            3'b011:  cond_true = eval_flags[1];
            3'b100:  cond_true = eval_flags[2] || (!eval_flags[2] && !eval_flags[1]);
            3'b101:  cond_true = eval_flags[1] || eval_flags[2];
            3'b110:  cond_true = eval_flags[0];
            default: cond_true = 1'b1;
        endcase
    end

    // Word offset: sign-extend then shift left one; the add wraps at WIDTH bits.
    assign imm_ext   = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    assign b_target  = bus.pc_plus2 + {imm_ext[WIDTH-2:0], 1'b0};
    assign br_accept = bus.br_valid && !bus.stall;

    always_comb begin
        resolve_valid_d = br_accept;
        flush_d         = br_accept && cond_true;
        taken_d         = taken_q;
        target_d        = target_q;
        if (br_accept) begin
            taken_d = cond_true;
            if (!cond_true) begin
                target_d = bus.pc_plus2;
            end else if (bus.br_reg) begin
                target_d = bus.rs_val;
            end else begin
                target_d = b_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q         <= 3'b000;
            resolve_valid_q <= 1'b0;
            taken_q         <= 1'b0;
            target_q        <= '0;
            flush_q         <= 1'b0;
        end else begin
            flags_q         <= flags_d;
            resolve_valid_q <= resolve_valid_d;
            taken_q         <= taken_d;
            target_q        <= target_d;
            flush_q         <= flush_d;
        end
    end

    assign bus.flags_q       = flags_q;
    assign bus.resolve_valid = resolve_valid_q;
    assign bus.taken         = taken_q;
    assign bus.target        = target_q;
    assign bus.flush         = flush_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed vector table, hand-written corner
// sequences, then random stimulus against a behavioural model.
module tb_flag_branch_unit;
    localparam int WIDTH = 16;
    localparam int IMM_W = 9;

    typedef struct packed {
        logic        alu_valid;
        logic [3:0]  op;
        logic        z;
        logic        n;
        logic        v;
        logic        stall;
        logic        br_valid;
        logic        br_reg;
        logic [2:0]  cond;
        logic [15:0] pc;
        logic [8:0]  imm;
        logic [15:0] rs;
        logic [2:0]  e_flags;
        logic        e_rv;
        logic        e_taken;
        logic [15:0] e_target;
        logic        e_flush;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flag_branch_if #(.WIDTH(WIDTH), .IMM_W(IMM_W)) bus ();
    flag_branch_unit #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];
    vec_t tbl[$];

    // Behavioural model state
    logic [2:0]  m_flags;
    logic        m_rv, m_taken, m_flush;
    logic [15:0] m_target;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.alu_valid  = v.alu_valid;
        bus.alu_opcode = v.op;
        bus.z_in       = v.z;
        bus.n_in       = v.n;
        bus.v_in       = v.v;
        bus.stall      = v.stall;
        bus.br_valid   = v.br_valid;
        bus.br_reg     = v.br_reg;
        bus.cond       = v.cond;
        bus.pc_plus2   = v.pc;
        bus.imm        = v.imm;
        bus.rs_val     = v.rs;
    endtask

    function automatic vec_t mk(
        input logic av, input logic [3:0] op, input logic z, input logic n, input logic v,
        input logic st, input logic bv, input logic br, input logic [2:0] c,
        input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] rs,
        input logic [2:0] ef, input logic erv, input logic et, input logic [15:0] etg,
        input logic efl);
        vec_t r;
        r.alu_valid = av; r.op = op; r.z = z; r.n = n; r.v = v; r.stall = st;
        r.br_valid = bv; r.br_reg = br; r.cond = c; r.pc = pc; r.imm = imm; r.rs = rs;
        r.e_flags = ef; r.e_rv = erv; r.e_taken = et; r.e_target = etg; r.e_flush = efl;
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, 16'h0, 3'b0, 0, 0, 16'h0, 0);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] f, input logic rv,
                             input logic t, input logic [15:0] tg, input logic fl);
        check({tag, ".flags"},  {29'd0, bus.flags_q}, {29'd0, f});
        check({tag, ".rv"},     {31'd0, bus.resolve_valid}, {31'd0, rv});
        check({tag, ".taken"},  {31'd0, bus.taken}, {31'd0, t});
        check({tag, ".target"}, {16'd0, bus.target}, {16'd0, tg});
        check({tag, ".flush"},  {31'd0, bus.flush}, {31'd0, fl});
    endtask

    // ---------------- reference model ----------------
    function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] f);
        logic z, n, v;
        z = f[2]; n = f[1]; v = f[0];
        case (c)
            3'd0: return z == 1'b0;
            3'd1: return z == 1'b1;
            3'd2: return (z == 1'b0) && (n == 1'b0);
            3'd3: return n == 1'b1;
            3'd4: return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
            3'd5: return (n == 1'b1) || (z == 1'b1);
            3'd6: return v == 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step(input vec_t v, input logic r);
        logic [2:0] nf, ef;
        logic ok;
        int off, pcv;
        if (r) begin
            m_flags = 3'b000; m_rv = 0; m_taken = 0; m_target = 16'h0; m_flush = 0;
            return;
        end
        nf = m_flags;
        if (v.alu_valid && !v.stall) begin
            if (v.op == 4'd0 || v.op == 4'd1) nf = {v.z, v.n, v.v};
            else if (v.op == 4'd2 || v.op == 4'd4 || v.op == 4'd5 || v.op == 4'd6) nf[2] = v.z;
        end
`ifdef FLAG_BYPASS_EN
        ef = nf;
`else
        ef = m_flags;
`endif
        if (v.br_valid && !v.stall) begin
            ok = cond_holds(v.cond, ef);
            off = $signed(v.imm);
            pcv = v.pc;
            m_rv = 1;
            m_taken = ok;
            m_flush = ok;
            if (!ok) m_target = v.pc;
            else if (v.br_reg) m_target = v.rs;
            else m_target = 16'(pcv + off * 2);
            exp_q.push_back(m_target);
        end else begin
            m_rv = 0;
            m_flush = 0;
        end
        m_flags = nf;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        logic r;
        logic [15:0] got_t;

        apply(idle());
        tick();
        check_out("reset", 3'b000, 0, 0, 16'h0, 0);
        rst = 1'b0;

        // av op z n v st bv br cond pc imm rs | flags rv taken target flush
        tbl.push_back(mk(1, 4'd0, 0, 1, 1, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b011, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1, 4'd2, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b111, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0100, 9'h005, 16'h0, 3'b111, 1, 0, 16'h0100, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b111, 0, 0, 16'h0100, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd1, 16'h0100, 9'h005, 16'h0, 3'b111, 1, 1, 16'h010A, 1));
        tbl.push_back(mk(1, 4'd1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b000, 0, 1, 16'h010A, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd2, 16'h0010, 9'h1FE, 16'h0, 3'b000, 1, 1, 16'h000C, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd3, 16'h0020, 9'h000, 16'h0, 3'b000, 1, 0, 16'h0020, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd4, 16'h0030, 9'h010, 16'h0, 3'b000, 1, 1, 16'h0050, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd5, 16'h0040, 9'h000, 16'h0, 3'b000, 1, 0, 16'h0040, 0));
        tbl.push_back(mk(1, 4'd0, 0, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b010, 0, 0, 16'h0040, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd3, 16'h0044, 9'h100, 16'h0, 3'b010, 1, 1, 16'hFE44, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd5, 16'h0060, 9'h000, 16'h0, 3'b010, 1, 1, 16'h0060, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd2, 16'h0070, 9'h000, 16'h0, 3'b010, 1, 0, 16'h0070, 0));
        tbl.push_back(mk(1, 4'd0, 1, 1, 1, 1, 1, 1, 3'd7, 16'h0000, 9'h000, 16'hBEEF, 3'b010, 0, 0, 16'h0070, 0));
        tbl.push_back(mk(1, 4'd8, 1, 1, 1, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b010, 0, 0, 16'h0070, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd6, 16'hFFFE, 9'h001, 16'h0, 3'b010, 1, 0, 16'hFFFE, 0));
        tbl.push_back(mk(1, 4'd0, 0, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b001, 0, 0, 16'hFFFE, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd6, 16'hFFFE, 9'h001, 16'h0, 3'b001, 1, 1, 16'h0000, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 1, 3'd3, 16'h0080, 9'h000, 16'h1234, 3'b001, 1, 0, 16'h0080, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 1, 3'd6, 16'h0090, 9'h000, 16'h1234, 3'b001, 1, 1, 16'h1234, 1));
        tbl.push_back(mk(1, 4'd6, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b101, 0, 1, 16'h1234, 0));
        tbl.push_back(mk(1, 4'd5, 0, 1, 1, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b001, 0, 1, 16'h1234, 0));
        tbl.push_back(mk(1, 4'd4, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b101, 0, 1, 16'h1234, 0));
        tbl.push_back(mk(1, 4'd3, 0, 1, 1, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 16'h0, 3'b101, 0, 1, 16'h1234, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 1, 3'd5, 16'h00A0, 9'h000, 16'hCAFE, 3'b101, 1, 1, 16'hCAFE, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd0, 16'h00A0, 9'h000, 16'h0, 3'b101, 1, 0, 16'h00A0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].e_flags, tbl[i].e_rv, tbl[i].e_taken,
                      tbl[i].e_target, tbl[i].e_flush);
        end

        // Stalled BR: no pulse for two cycles, then exactly one pulse on release.
        apply(mk(0, 4'd0, 0, 0, 0, 1, 1, 1, 3'd7, 16'h0002, 9'h000, 16'hBEEF, 3'b0, 0, 0, 16'h0, 0));
        tick();
        check_out("stall1", 3'b101, 0, 0, 16'h00A0, 0);
        tick();
        check_out("stall2", 3'b101, 0, 0, 16'h00A0, 0);
        bus.stall = 1'b0;
        tick();
        check_out("stall_rel", 3'b101, 1, 1, 16'hBEEF, 1);
        apply(idle());
        tick();
        check_out("stall_after", 3'b101, 0, 1, 16'hBEEF, 0);

        // Flag update and branch in the same cycle.
        apply(mk(1, 4'd1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, 16'h0, 3'b0, 0, 0, 16'h0, 0));
        tick();
        check("byp_pre.flags", {29'd0, bus.flags_q}, 32'd0);
        apply(mk(1, 4'd1, 1, 0, 0, 0, 1, 0, 3'd1, 16'h0200, 9'h004, 16'h0, 3'b0, 0, 0, 16'h0, 0));
        tick();
`ifdef FLAG_BYPASS_EN
        check_out("bypass", 3'b100, 1, 1, 16'h0208, 1);
`else
        check_out("bypass", 3'b100, 1, 0, 16'h0200, 0);
`endif

        // Reset while a resolution pulse is on the outputs.
        apply(mk(1, 4'd0, 1, 1, 1, 0, 0, 0, 3'd0, 16'h0, 9'h0, 16'h0, 3'b0, 0, 0, 16'h0, 0));
        tick();
        apply(mk(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'd7, 16'h0300, 9'h000, 16'h0, 3'b0, 0, 0, 16'h0, 0));
        tick();
        check_out("pre_rst", 3'b111, 1, 1, 16'h0300, 1);
        rst = 1'b1;
        #1;
        check_out("rst_async", 3'b000, 0, 0, 16'h0, 0);
        tick();
        check_out("rst_hold", 3'b000, 0, 0, 16'h0, 0);
        rst = 1'b0;

        // Reset asserted between acceptance setup and the edge: no pulse at all.
        apply(mk(1, 4'd0, 1, 1, 1, 0, 1, 0, 3'd7, 16'h0400, 9'h000, 16'h0, 3'b0, 0, 0, 16'h0, 0));
        #2;
        rst = 1'b1;
        tick();
        check_out("rst_pre_edge", 3'b000, 0, 0, 16'h0, 0);
        rst = 1'b0;
        apply(idle());
        tick();
        check_out("rst_release", 3'b000, 0, 0, 16'h0, 0);

        // Random phase against the model; model starts from the reset state.
        model_step(idle(), 1'b1);
        exp_q.delete();
        for (int k = 0; k < 600; k++) begin
            v = idle();
            v.alu_valid = 1'($urandom_range(0, 1));
            v.op        = 4'($urandom_range(0, 15));
            v.z         = 1'($urandom_range(0, 1));
            v.n         = 1'($urandom_range(0, 1));
            v.v         = 1'($urandom_range(0, 1));
            v.stall     = ($urandom_range(0, 3) == 0);
            v.br_valid  = 1'($urandom_range(0, 1));
            v.br_reg    = 1'($urandom_range(0, 1));
            v.cond      = 3'($urandom_range(0, 7));
            v.pc        = 16'($urandom_range(0, 65535));
            v.imm       = 9'($urandom_range(0, 511));
            v.rs        = 16'($urandom_range(0, 65535));
            r           = ($urandom_range(0, 59) == 0);
            apply(v);
            rst = r;
            model_step(v, r);
            tick();
            check_out($sformatf("rnd%0d", k), m_flags, m_rv, m_taken, m_target, m_flush);
            if (bus.resolve_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("rnd%0d.q_empty", k), 32'd1, 32'd0);
                end else begin
                    got_t = exp_q.pop_front();
                    check($sformatf("rnd%0d.q_target", k), {16'd0, bus.target}, {16'd0, got_t});
                end
            end
            rst = 1'b0;
        end
        apply(idle());
        tick();
        check("rnd_q_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
